shift_sequencer: RTL

//   Multicycle sequencer for the datapath shift unit: serves SLL/SRL/SRA/ROR for

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and operand bundle between the main control FSM and the shift sequencer.
// The master side issues requests. The slave side (the sequencer) reports busy, done and the result.
interface shift_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
);
  logic              start;
  logic [1:0]        op;
  logic              amt_sel;
  logic [AMT_W-1:0]  shamt_instr;
  logic [DATA_W-1:0] shamt_reg;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, op, amt_sel, shamt_instr, shamt_reg, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, op, amt_sel, shamt_instr, shamt_reg, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multicycle SLL/SRL/SRA/ROR unit that moves one bit position per clock.
// The shift amount is taken from the instruction shamt field or from the low bits of a register operand.
module shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_e;

  state_e            state, state_nxt;
  op_e               op_q;
  logic [AMT_W-1:0]  count;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [AMT_W-1:0]  amount;
  logic              accept;

  // Only the low AMT_W bits of the register operand select the amount.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^bus.shamt_reg[DATA_W-1:AMT_W];

  assign amount = bus.amt_sel ? bus.shamt_reg[AMT_W-1:0] : bus.shamt_instr;
  assign accept = bus.start && (state == IDLE || state == DONE);

  // State register
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (amount != '0) ? SHIFT : DONE;
        else        state_nxt = IDLE;
      end
      SHIFT:   if (count == AMT_W'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    bus.busy   = (state == SHIFT);
    bus.done   = (state == DONE);
    bus.result = shreg;
  end

  // One-position shift of the working register
  always_comb begin
    shifted = shreg;
    unique case (op_q)
      OP_SLL:  shifted = {shreg[DATA_W-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, shreg[DATA_W-1:1]};
      OP_SRA:  shifted = {shreg[DATA_W-1], shreg[DATA_W-1:1]};
      OP_ROR:  shifted = {shreg[0], shreg[DATA_W-1:1]};
      default: shifted = shreg;
    endcase
  end

  // Datapath: load on accept, step while shifting, hold otherwise.
  // NOTE: every datapath flop is reset, so an aborted operation leaves no stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
      op_q  <= OP_SLL;
    end else if (accept) begin
      shreg <= bus.data_in;
      count <= amount;
      op_q  <= op_e'(bus.op);
    end else if (state == SHIFT) begin
      shreg <= shifted;
      count <= count - AMT_W'(1);
    end
  end

endmodule
